instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction memory. Owns the program counter and drives the memory's byte address.
- Captures the combinational read data into a small instruction buffer and presents {pc, instr} to the decoder over a valid/ready handshake.
- Handles control-flow redirects (flushing the buffer) and raises faults for misaligned targets and fetches beyond the memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_SIZE_BYTES, 4096, fetch window size; a PC >= this value is out of range.
- BUF_DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- fetch_en_i  in  1  when 1, fetching is allowed; when 0, no new pushes, and the buffer still drains.
- redirect_i  in  1  branch/jump taken; highest priority.
- redirect_pc_i  in  32  redirect target byte address.
- imem_addr_o  out  32  byte address to the instruction memory; equals pc_q.
- imem_rdata_i  in  32  combinational read data for imem_addr_o.
- instr_o  out  32  instruction at the buffer head.
- instr_pc_o  out  32  PC of instr_o.
- instr_valid_o  out  1  buffer head is valid.
- instr_ready_i  in  1  decoder accepts the head this cycle.
- fault_o  out  1  fetch fault pending; sticky until the next redirect.
- fault_cause_o  out  2  01 = misaligned redirect, 10 = out-of-range PC, 00 = none.
- fault_pc_o  out  32  offending address.

Behaviour:
- Reset (asynchronous, rst_ni = 0):
  - pc_q = RESET_PC, buffer count = 0, rd/wr pointers = 0, state = RUN.
  - Outputs: instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, fault_o = 0, fault_cause_o = 00, fault_pc_o = 0.
  - Reset mid-operation discards all buffered entries immediately.
- States:
  - RUN: normal fetch.
  - FAULT: no fetches; left only via redirect_i.
- Pop: pop = instr_valid_o & instr_ready_i. instr_valid_o = (count != 0).
- Push condition: state == RUN, fetch_en_i = 1, redirect_i = 0, pc_q < IMEM_SIZE_BYTES, and (count < BUF_DEPTH or pop).
- Push effect: writes {pc_q, imem_rdata_i} at the write pointer; pc_q <= pc_q + 4.
- Push and pop in the same cycle: count is unchanged. Pushing while full is legal only with a simultaneous pop.
- Full buffer without pop: pc_q holds; imem_addr_o is stable.
- Out of range: in RUN with fetch_en_i = 1 and pc_q >= IMEM_SIZE_BYTES, go to FAULT with cause 10 and fault_pc_o = pc_q. No push occurs. Entries already in the buffer still drain normally.
- Fault reporting is precise: fault_o = (state == FAULT) & (count == 0). fault_cause_o and fault_pc_o are held from FAULT entry; fault_o only rises once older instructions have drained.
- Redirect (any state): the buffer is flushed (count = 0; pointers reset) in the same edge, and any pop that cycle is ignored.
  - Aligned target (redirect_pc_i[1:0] = 00): pc_q <= redirect_pc_i; state = RUN; fault cleared.
  - Misaligned target: pc_q <= redirect_pc_i; state = FAULT; cause 01; fault_pc_o = redirect_pc_i. fault_o = 1 the next cycle, since the buffer is empty.
- Latency, baseline: redirect asserted at edge N → pc_q = target after edge N → entry pushed at edge N+1 → instr_valid_o = 1 after edge N+1. Net: one cycle between imem_addr_o and instr_valid_o.
- Arithmetic:
  - pc_q + 4 is 32-bit modulo. Wrap is unreachable in RUN because the out-of-range check fires first.
  - The out-of-range comparison is unsigned.
- fetch_en_i = 0: pc_q and state hold; redirect still applies.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when count == 0, state == RUN, fetch_en_i = 1, redirect_i = 0 and pc_q is in range:
  - instr_valid_o = 1 combinationally, with instr_o = imem_rdata_i and instr_pc_o = pc_q.
  - If instr_ready_i = 1, pc_q advances and nothing is written to the buffer.
  - If instr_ready_i = 0, the entry is pushed as normal.
  - Result: zero-cycle fetch-to-valid latency when the buffer is empty.
- Undefined: outputs come only from the buffer (one-cycle latency as in Behaviour).

Test Plan:
- Reset release, ready = 1, memory returns {pc}: instr_pc_o sequence 0x0, 0x4, 0x8 with instr_o == instr_pc_o. First valid one cycle after release (zero cycles with FETCH_BYPASS_EN).
- Back-pressure:
  - Hold ready = 0 for 5 cycles: count saturates at 2 and pc_q holds at 0x8.
  - Release: entries 0x0, 0x4, 0x8 delivered in order with none dropped or duplicated.
- Redirect while full, to 0x100: next valid instr_pc_o = 0x100; entries 0x0/0x4 never appear; a simultaneous pop is ignored.
- Redirect to 0x102:
  - Next cycle: fault_o = 1, cause = 01, fault_pc_o = 0x102, instr_valid_o = 0.
  - Then redirect to 0x200: fault cleared, fetch resumes at 0x200.
- Redirect to 0xFF8, ready = 0:
  - 0xFF8 and 0xFFC are buffered; state goes to FAULT with cause 10 and fault_pc_o = 0x1000, but fault_o stays 0.
  - Raise ready: both entries drain, then fault_o = 1.
- Assert rst_ni = 0 mid-stream with 2 entries buffered: instr_valid_o = 0 immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, drives the instruction memory address, buffers
// fetched words and hands {pc, instr} to the decoder over valid/ready.
// Optional build macro FETCH_BYPASS_EN: when the buffer is empty the memory
// word is forwarded straight to the decoder in the same cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | normal sequential fetch
// S_FAULT | fetch stopped (misaligned redirect or PC beyond memory);
//         | left only through a redirect
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned IMEM_SIZE_BYTES = 4096,
  parameter int unsigned BUF_DEPTH       = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] fault_pc_o
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0]   IMEM_LIMIT = 32'(IMEM_SIZE_BYTES);
  localparam logic [CW-1:0] DEPTH_C    = CW'(BUF_DEPTH);

  typedef enum logic {S_RUN, S_FAULT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   buf_pc_q  [BUF_DEPTH];
  logic [31:0]   buf_ins_q [BUF_DEPTH];

  logic in_range, buf_nonempty, fetch_ok, bypass, pop_buf, push, push_buf, oor;

  // Fetch/handshake qualifiers shared by the datapath and the FSM
  always_comb begin
    in_range     = (pc_q < IMEM_LIMIT);
    buf_nonempty = (cnt_q != '0);
    fetch_ok     = (state_q == S_RUN) & fetch_en_i & ~redirect_i;
`ifdef FETCH_BYPASS_EN
    bypass       = fetch_ok & in_range & ~buf_nonempty;
`else
    bypass       = 1'b0;
`endif
    pop_buf      = buf_nonempty & instr_ready_i;
    push         = fetch_ok & in_range & ((cnt_q < DEPTH_C) | pop_buf);
    // a bypassed word that the decoder takes right away never enters the buffer
    push_buf     = push & ~(bypass & instr_ready_i);
    oor          = fetch_ok & ~in_range;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  // Next-state logic: redirect wins, otherwise an out-of-range PC stops fetch
  always_comb begin
    state_d = state_q;
    if (redirect_i)
      state_d = (redirect_pc_i[1:0] != 2'b00) ? S_FAULT : S_RUN;
    else if (oor)
      state_d = S_FAULT;
  end

  // FSM outputs; fault is reported only once older instructions have drained
  always_comb begin
    instr_valid_o = buf_nonempty | bypass;
    fault_o       = (state_q == S_FAULT) & ~buf_nonempty;
    if (bypass) begin
      instr_o    = imem_rdata_i;
      instr_pc_o = pc_q;
    end else if (buf_nonempty) begin
      instr_o    = buf_ins_q[rd_q];
      instr_pc_o = buf_pc_q[rd_q];
    end else begin
      instr_o    = '0;
      instr_pc_o = '0;
    end
  end

  // Next values for PC, buffer bookkeeping and fault record
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cause_d = cause_q;
    fpc_d   = fpc_q;
    if (redirect_i) begin
      pc_d  = redirect_pc_i;
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        cause_d = 2'b01;
        fpc_d   = redirect_pc_i;
      end else begin
        cause_d = 2'b00;
        fpc_d   = '0;
      end
    end else begin
      if (push)     pc_d = pc_q + 32'd4;
      if (pop_buf)  rd_d = rd_q + PW'(1);
      if (push_buf) wr_d = wr_q + PW'(1);
      cnt_d = cnt_q + CW'(push_buf) - CW'(pop_buf);
      if (oor) begin
        cause_d = 2'b10;
        fpc_d   = pc_q;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cause_q <= 2'b00;
      fpc_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cause_q <= cause_d;
      fpc_q   <= fpc_d;
    end
  end

  // Buffer storage; contents are only observable through a nonzero count
  always_ff @(posedge clk_i) begin
    if (push_buf) begin
      buf_pc_q[wr_q]  <= pc_q;
      buf_ins_q[wr_q] <= imem_rdata_i;
    end
  end

  assign imem_addr_o   = pc_q;
  assign fault_cause_o = cause_q;
  assign fault_pc_o    = fpc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] SIZE     = 32'd4096;
  localparam int          DEPTH    = 2;

  logic        clk, rst_n, fetch_en, redirect, ready;
  logic [31:0] rpc, mem_xor;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, fault_pc;
  logic        instr_valid, fault;
  logic [1:0]  fault_cause;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_SIZE_BYTES(4096), .BUF_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en), .redirect_i(redirect),
    .redirect_pc_i(rpc), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .instr_o(instr), .instr_pc_o(instr_pc), .instr_valid_o(instr_valid),
    .instr_ready_i(ready), .fault_o(fault), .fault_cause_o(fault_cause),
    .fault_pc_o(fault_pc)
  );

  // memory contents: each word is its own address XOR a scramble value
  assign imem_rdata = imem_addr ^ mem_xor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  bit          m_flt;
  logic [1:0]  m_cause;
  logic [31:0] m_fpc;
  bit          m_bypass, m_valid, m_pop;
  int          m_occ;

  // Compare DUT against model mid-cycle, then advance model to the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_ipc", instr_pc, 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_cause", 32'(fault_cause), 32'h0);
      chk("rst_fpc", fault_pc, 32'h0);
      m_pc = RESET_PC; q_pc.delete(); q_ins.delete();
      m_flt = 0; m_cause = 2'b00; m_fpc = 32'h0;
    end else begin
      m_occ = q_pc.size();
`ifdef FETCH_BYPASS_EN
      m_bypass = (m_occ == 0) && !m_flt && fetch_en && !redirect && (m_pc < SIZE);
`else
      m_bypass = 0;
`endif
      m_valid = (m_occ != 0) || m_bypass;
      chk("addr", imem_addr, m_pc);
      chk("valid", 32'(instr_valid), 32'(m_valid));
      if (m_valid) begin
        chk("instr_pc", instr_pc, (m_occ != 0) ? q_pc[0] : m_pc);
        chk("instr", instr, (m_occ != 0) ? q_ins[0] : (m_pc ^ mem_xor));
      end
      chk("fault", 32'(fault), 32'(m_flt && (m_occ == 0)));
      chk("cause", 32'(fault_cause), 32'(m_cause));
      chk("fault_pc", fault_pc, m_fpc);
      // model state after the coming rising edge
      m_pop = m_valid && ready;
      if (redirect) begin
        q_pc.delete(); q_ins.delete();
        m_pc = rpc;
        if (rpc[1:0] != 2'b00) begin m_flt = 1; m_cause = 2'b01; m_fpc = rpc; end
        else begin m_flt = 0; m_cause = 2'b00; m_fpc = 32'h0; end
      end else begin
        if (m_pop && m_occ != 0) begin void'(q_pc.pop_front()); void'(q_ins.pop_front()); end
        if (!m_flt && fetch_en) begin
          if (m_pc >= SIZE) begin
            m_flt = 1; m_cause = 2'b10; m_fpc = m_pc;
          end else if (m_occ < DEPTH || m_pop) begin
            if (!(m_bypass && ready)) begin
              q_pc.push_back(m_pc);
              q_ins.push_back(m_pc ^ mem_xor);
            end
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; fetch_en = 0; ready = 0; redirect = 0; rpc = 0; mem_xor = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("lit_rst_valid", 32'(instr_valid), 32'h0);
    chk("lit_rst_addr", imem_addr, 32'h0);

    // reset release, ready high, memory returns its own address
    rst_n = 1; fetch_en = 1; ready = 1;
    #1;
`ifndef FETCH_BYPASS_EN
    chk("lit_first_not_yet", 32'(instr_valid), 32'h0);
    tick(); chk("lit_seq0_pc", instr_pc, 32'h0); chk("lit_seq0_ins", instr, 32'h0);
    tick(); chk("lit_seq1_pc", instr_pc, 32'h4); chk("lit_seq1_ins", instr, 32'h4);
    tick(); chk("lit_seq2_pc", instr_pc, 32'h8); chk("lit_seq2_ins", instr, 32'h8);
`else
    tick(); tick(); tick();
`endif

    // back-pressure from a fresh start at 0
    redirect = 1; rpc = 32'h0; ready = 0;
    tick(); redirect = 0;
    repeat (5) tick();
    chk("lit_bp_addr_hold", imem_addr, 32'h8);
    chk("lit_bp_head", instr_pc, 32'h0);
    ready = 1;
    tick(); chk("lit_bp_drain1", instr_pc, 32'h4);
    tick(); chk("lit_bp_drain2", instr_pc, 32'h8);

    // redirect while full, with a pop offered the same cycle
    redirect = 1; rpc = 32'h0; ready = 0;
    tick(); redirect = 0;
    tick(); tick();
    chk("lit_full_head", instr_pc, 32'h0);
    redirect = 1; rpc = 32'h100; ready = 1;
    tick(); redirect = 0;
`ifndef FETCH_BYPASS_EN
    chk("lit_flush_empty", 32'(instr_valid), 32'h0);
    tick();
`endif
    chk("lit_redir_target", instr_pc, 32'h100);

    // misaligned redirect, then recovery
    redirect = 1; rpc = 32'h102;
    tick(); redirect = 0;
    chk("lit_mis_fault", 32'(fault), 32'h1);
    chk("lit_mis_cause", 32'(fault_cause), 32'h1);
    chk("lit_mis_fpc", fault_pc, 32'h102);
    chk("lit_mis_valid", 32'(instr_valid), 32'h0);
    tick(); tick();
    chk("lit_mis_addr_hold", imem_addr, 32'h102);
    redirect = 1; rpc = 32'h200;
    tick(); redirect = 0;
    chk("lit_recover_fault", 32'(fault), 32'h0);
    chk("lit_recover_cause", 32'(fault_cause), 32'h0);
`ifndef FETCH_BYPASS_EN
    tick();
`endif
    chk("lit_recover_pc", instr_pc, 32'h200);

    // run off the end of memory with older entries still buffered
    redirect = 1; rpc = 32'hFF8; ready = 0;
    tick(); redirect = 0;
    tick(); tick(); tick();
    chk("lit_end_fault_hidden", 32'(fault), 32'h0);
    chk("lit_end_cause", 32'(fault_cause), 32'h2);
    chk("lit_end_fpc", fault_pc, 32'h1000);
    chk("lit_end_head", instr_pc, 32'hFF8);
    ready = 1;
    tick(); chk("lit_end_drain", instr_pc, 32'hFFC);
    chk("lit_end_still_hidden", 32'(fault), 32'h0);
    tick(); chk("lit_end_fault", 32'(fault), 32'h1);
    chk("lit_end_empty", 32'(instr_valid), 32'h0);

    // asynchronous reset with two entries buffered
    redirect = 1; rpc = 32'h40; ready = 0;
    tick(); redirect = 0;
    tick(); tick();
    chk("lit_pre_rst_head", instr_pc, 32'h40);
    rst_n = 0;
    #1 chk("lit_async_rst", 32'(instr_valid), 32'h0);
    tick(); tick();
    rst_n = 1; ready = 1;
`ifndef FETCH_BYPASS_EN
    tick();
`endif
    chk("lit_restart_pc", instr_pc, RESET_PC);
    tick(); tick();

    // randomized traffic
    mem_xor = $urandom;
    for (int i = 0; i < 3000; i++) begin
      ready    = ($urandom_range(0, 3) != 0);
      fetch_en = ($urandom_range(0, 7) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: rpc = {20'h0, $urandom_range(0, 1023) * 4};
        1: rpc = {20'h0, 12'($urandom_range(0, 4095))} | 32'h1;
        2: rpc = 32'hFE0 + 32'($urandom_range(0, 7) * 4);
        default: rpc = 32'hFFFF_FFF0;
      endcase
      if (i % 500 == 499) mem_xor = $urandom;
      tick();
    end
    redirect = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
